mobo_mem_resp: RTL

MOBO_MEM_RESP -- requirements
Module: mobo_mem_resp

---
 rtl/mobo_mem_resp.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mobo_mem_resp.sv
// ---------------------------------------------------------------------------
// mobo_mem_resp
//   Memory-backed responder for a CPU mailbox.
//
//   The CPU posts a command on mobo_ctrl. The block latches the address and
//   data, waits a fixed latency and then either commits the write or returns
//   the read data. Completion is reported on mobo_stat, and the CPU closes
//   the transaction with a 4-phase handshake by returning the command to 00.
//
//   Parameters
//     word_width : data/address/control width (>= 3), default `WORD_WIDTH
//     MEM_DEPTH  : number of storage words, power of two, >= 2
//     READ_LAT   : cycles from command capture to done, >= 1
//
//   Ports
//     clk         in   system clock, rising edge
//     rst         in   synchronous active-high reset
//     mobo_ctrl   in   [1:0] command: 00 idle, 01 read, 10 write, 11 reserved
//     mobo_stat   out  bit0 busy, bit1 done, bit2 err, other bits 0
//     addr_in     in   word address
//     mobodat_in  in   write data
//     mobodat_out out  read data, held until the next read completes
//
//   Optional feature
//     MOBO_RESP_BOUNDS_EN : when defined, addresses >= MEM_DEPTH flag err,
//                           drop writes and read back as 0. When undefined
//                           the address wraps modulo MEM_DEPTH and err is 0.
// ---------------------------------------------------------------------------
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mobo_mem_resp #(
   parameter int word_width = `WORD_WIDTH,
   parameter int MEM_DEPTH  = 256,
   parameter int READ_LAT   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [word_width-1:0] mobo_ctrl,
   output logic [word_width-1:0] mobo_stat,
   input  logic [word_width-1:0] addr_in,
   input  logic [word_width-1:0] mobodat_in,
   output logic [word_width-1:0] mobodat_out
);

   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   // Counter only has to hold READ_LAT-1.
   localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [CW-1:0] LAT_M1 = CW'(READ_LAT - 1);

   localparam logic [1:0] CMD_IDLE = 2'b00;
   localparam logic [1:0] CMD_RD   = 2'b01;
   localparam logic [1:0] CMD_WR   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  is_wr_q, is_wr_d;
   logic [word_width-1:0] addr_q, addr_d;
   logic [word_width-1:0] wdata_q, wdata_d;
   logic [word_width-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [word_width-1:0] mem [MEM_DEPTH];

   logic [1:0]            cmd;
   logic [AW-1:0]         idx;
   logic                  oob;
   logic                  finish;
   logic                  mem_we;

   assign cmd = mobo_ctrl[1:0];
   assign idx = addr_q[AW-1:0];

`ifdef MOBO_RESP_BOUNDS_EN
   // Extra top bit keeps the compare correct when MEM_DEPTH == 2**word_width.
   assign oob = ({1'b0, addr_q} >= (word_width + 1)'(MEM_DEPTH));
`else
   // Low address bits only; the address simply wraps.
   assign oob = 1'b0;
`endif

   // Last BUSY cycle: the edge that closes it is the BUSY->DONE edge.
   assign finish = (state_q == ST_BUSY) && (cnt_q == '0);
   assign mem_we = finish && is_wr_q && !oob;

   // ------------------------------------------------------------------
   // Next-state / datapath
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      is_wr_d = is_wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd == CMD_RD || cmd == CMD_WR) begin
               state_d = ST_BUSY;
               cnt_d   = LAT_M1;
               is_wr_d = (cmd == CMD_WR);
               addr_d  = addr_in;
               wdata_d = mobodat_in;
            end
         end

         ST_BUSY: begin
            // Inputs are not looked at here; only the latched copies matter.
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               err_d   = oob;
               if (!is_wr_q)
                  rdata_d = oob ? '0 : mem[idx];
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_DONE: begin
            // Hold done until the CPU drops the command.
            if (cmd == CMD_IDLE) begin
               state_d = ST_IDLE;
               err_d   = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         is_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         is_wr_q <= is_wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage survives reset; reset only blocks a commit on the same edge,
   // which is how an in-flight write gets aborted.
   always_ff @(posedge clk) begin
      if (!rst && mem_we)
         mem[idx] <= wdata_q;
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      mobo_stat    = '0;
      mobo_stat[0] = (state_q == ST_BUSY);
      mobo_stat[1] = (state_q == ST_DONE);
      mobo_stat[2] = err_q;
   end

   assign mobodat_out = rdata_q;

   // Command upper bits are don't-care; high address bits are only
   // consulted when bounds checking is built in.
   logic unused_bits;
   assign unused_bits = ^{mobo_ctrl[word_width-1:2], addr_q};

endmodule
